// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phases, nibble/byte types and
// the OPR codes the bus sequencer decodes.
package mcs4;
  localparam int ADDR_W = 12;

  typedef logic [3:0] char_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  localparam char_t OPR_IO  = 4'hE;
  localparam char_t OPR_SRC = 4'h2;
endpackage

// File: rtl/mcs4_bus_ctrl_if.sv
// Shared MCS-4 bus as seen by the CPU-side sequencer (master) and the
// ROM/RAM responders (slave). dbus_in is the wired-OR of every driver.
interface mcs4_bus_ctrl_if;
  import mcs4::*;
  char_t dbus_in;
  char_t dbus_out;
  logic  sync;
  logic  cm_rom;
  logic  cl_rom;

  modport master (input dbus_in, output dbus_out, sync, cm_rom, cl_rom);
  modport slave  (output dbus_in, input dbus_out, sync, cm_rom, cl_rom);
endinterface

// File: rtl/mcs4_bus_ctrl_cyc_gen.sv
// 8-phase instruction-cycle counter with registered sync and the
// first-cycle cl_rom hold.
module mcs4_cyc_gen
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst,
  output instr_cyc_t phase_o,
  output logic       sync_o,
  output logic       cl_rom_o
);
  instr_cyc_t phase_q, phase_d;
  logic sync_q, sync_d, cl_q, cl_d, run_q;

  always_comb begin
    phase_d = instr_cyc_t'(phase_q + 3'd1);
    sync_d  = (phase_d == X3);
    cl_d    = cl_q;
    // The reset-time X3 is not a real cycle; only a later X3 clears cl_rom.
    if (phase_q == X3 && run_q) cl_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= X3;
      sync_q  <= 1'b1;
      cl_q    <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sync_q  <= sync_d;
      cl_q    <= cl_d;
      run_q   <= 1'b1;
    end
  end

  assign phase_o  = phase_q;
  assign sync_o   = sync_q;
  assign cl_rom_o = cl_q;
endmodule

// File: rtl/mcs4_bus_ctrl.sv
// CPU-side MCS-4 bus sequencer: address drive, OPR/OPA capture, cm_rom and
// execute-phase data. `MCS4_BUS_CHK_EN builds the sticky contention checker.
module mcs4_bus_ctrl
  import mcs4::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  char_t             acc_in,
  input  byte_t             src_in,
  mcs4_bus_ctrl_if.master   bus,
  output instr_cyc_t        phase,
  output logic              instr_vld,
  output char_t             opr,
  output char_t             opa,
  output logic              rd_vld,
  output char_t             rd_data,
  output logic              bus_err
);
  instr_cyc_t        phase_w;
  logic              sync_w, cl_w;
  logic [ADDR_W-1:0] addr_q, addr_d;
  char_t             opr_q, opr_d, opa_q, opa_d, src_lo_q, src_lo_d;
  char_t             rd_q, rd_d, dout_q, dout_d;
  logic              cm_q, cm_d, ivld_q, ivld_d, rvld_q, rvld_d;
  logic              is_io, is_src, is_wr, is_rd;

  mcs4_cyc_gen u_cyc (
    .clk      (clk),
    .rst      (rst),
    .phase_o  (phase_w),
    .sync_o   (sync_w),
    .cl_rom_o (cl_w)
  );

  assign is_io  = (opr_q == OPR_IO);
  assign is_src = (opr_q == OPR_SRC) && opa_q[0];
  assign is_wr  = is_io && !opa_q[3];
  assign is_rd  = is_io && opa_q[3];

  // Outputs are registered, so each branch computes what the *next* phase shows.
  always_comb begin
    addr_d   = addr_q;
    opr_d    = opr_q;
    opa_d    = opa_q;
    src_lo_d = src_lo_q;
    rd_d     = rd_q;
    dout_d   = '0;
    cm_d     = 1'b0;
    ivld_d   = 1'b0;
    rvld_d   = 1'b0;
    case (phase_w)
      X3: begin
        addr_d = pc_in;
        dout_d = pc_in[3:0];
      end
      A1: dout_d = addr_q[7:4];
      A2: dout_d = addr_q[11:8];
      M1: begin
        opr_d = bus.dbus_in;
        cm_d  = (bus.dbus_in == OPR_IO);
      end
      M2: begin
        opa_d  = bus.dbus_in;
        ivld_d = 1'b1;
      end
      X1: begin
        src_lo_d = src_in[3:0];
        cm_d     = is_src;
        dout_d   = is_src ? src_in[7:4] : (is_wr ? acc_in : '0);
      end
      X2: begin
        dout_d = is_src ? src_lo_q : '0;
        if (is_rd) begin
          rd_d   = bus.dbus_in;
          rvld_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      opr_q    <= '0;
      opa_q    <= '0;
      src_lo_q <= '0;
      rd_q     <= '0;
      dout_q   <= '0;
      cm_q     <= 1'b0;
      ivld_q   <= 1'b0;
      rvld_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      opr_q    <= opr_d;
      opa_q    <= opa_d;
      src_lo_q <= src_lo_d;
      rd_q     <= rd_d;
      dout_q   <= dout_d;
      cm_q     <= cm_d;
      ivld_q   <= ivld_d;
      rvld_q   <= rvld_d;
    end
  end

`ifdef MCS4_BUS_CHK_EN
  logic err_q, err_d, drv;

  always_comb begin
    drv   = (phase_w == A1) || (phase_w == A2) || (phase_w == A3) ||
            (phase_w == X2 && (is_src || is_wr)) || (phase_w == X3 && is_src);
    err_d = err_q;
    if (drv && (bus.dbus_in != dout_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign bus.dbus_out = dout_q;
  assign bus.cm_rom   = cm_q;
  assign bus.sync     = sync_w;
  assign bus.cl_rom   = cl_w;
  assign phase        = phase_w;
  assign instr_vld    = ivld_q;
  assign opr          = opr_q;
  assign opa          = opa_q;
  assign rd_vld       = rvld_q;
  assign rd_data      = rd_q;
endmodule

// File: tb/tb_mcs4_bus_ctrl.sv
// Directed bench for mcs4_bus_ctrl: a ROM/RAM responder model on the wired-OR
// bus and a per-phase scoreboard of expected master behaviour.
module tb_mcs4_bus_ctrl;
  import mcs4::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [11:0] pc_in = '0;
  char_t      acc_in = '0;
  byte_t      src_in = '0;
  instr_cyc_t phase;
  logic       instr_vld, rd_vld, bus_err;
  char_t      opr, opa, rd_data;

  byte_t rom = '0;
  char_t rd_nib = '0;
  char_t resp;
  logic  inj = 1'b0;
  logic  first = 1'b1;
  logic  exp_err = 1'b0;
  int    total = 0;
  int    passed = 0;

  typedef struct {
    instr_cyc_t ph;
    char_t      dout;
    logic       cm, sy, iv, rv;
    char_t      opr, opa, rdd;
  } exp_t;
  exp_t sb[$];

  mcs4_bus_ctrl_if bus();

  mcs4_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .acc_in    (acc_in),
    .src_in    (src_in),
    .bus       (bus),
    .phase     (phase),
    .instr_vld (instr_vld),
    .opr       (opr),
    .opa       (opa),
    .rd_vld    (rd_vld),
    .rd_data   (rd_data),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Responder: ROM returns OPR/OPA in M1/M2, RAM returns rd_nib in X2,
  // optional contention injected on A2.
  always_comb begin
    resp = '0;
    case (phase)
      A2: if (inj) resp = 4'h1;
      M1: resp = rom[7:4];
      M2: resp = rom[3:0];
      X2: resp = rd_nib;
      default: ;
    endcase
  end
  assign bus.dbus_in = bus.dbus_out | resp;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_cycle(input logic [11:0] pc, input byte_t b, input char_t acc,
                           input byte_t src, input char_t rdn, input logic injv);
    exp_t e;
    char_t o, a;
    logic io, srcf, wr, rd;
    pc_in = pc; rom = b; acc_in = acc; src_in = src; rd_nib = rdn; inj = injv;
    o = b[7:4]; a = b[3:0];
    io = (o == 4'hE); srcf = (o == 4'h2) && a[0]; wr = io && !a[3]; rd = io && a[3];
    for (int i = 0; i < 8; i++) begin
      e.ph = instr_cyc_t'(i);
      e.dout = '0; e.cm = 1'b0; e.sy = 1'b0; e.iv = 1'b0; e.rv = 1'b0;
      e.opr = o; e.opa = a; e.rdd = rdn;
      case (e.ph)
        A1: e.dout = pc[3:0];
        A2: e.dout = pc[7:4];
        A3: e.dout = pc[11:8];
        M2: e.cm = io;
        X1: e.iv = 1'b1;
        X2: begin e.cm = srcf; e.dout = srcf ? src[7:4] : (wr ? acc : 4'h0); end
        X3: begin e.sy = 1'b1; e.rv = rd; e.dout = srcf ? src[3:0] : 4'h0; end
        default: ;
      endcase
      sb.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk("phase", 12'(phase), 12'(e.ph));
      chk("dbus_out", 12'(bus.dbus_out), 12'(e.dout));
      chk("cm_rom", 12'(bus.cm_rom), 12'(e.cm));
      chk("sync", 12'(bus.sync), 12'(e.sy));
      chk("cl_rom", 12'(bus.cl_rom), 12'(first));
      chk("instr_vld", 12'(instr_vld), 12'(e.iv));
      chk("rd_vld", 12'(rd_vld), 12'(e.rv));
      chk("bus_err", 12'(bus_err), 12'(exp_err));
      if (e.iv) begin
        chk("opr", 12'(opr), 12'(e.opr));
        chk("opa", 12'(opa), 12'(e.opa));
      end
      if (e.rv) chk("rd_data", 12'(rd_data), 12'(e.rdd));
`ifdef MCS4_BUS_CHK_EN
      if (injv && e.ph == A2) exp_err = 1'b1;
`endif
    end
    first = 1'b0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_phase"}, 12'(phase), 12'(X3));
    chk({pfx, "_sync"}, 12'(bus.sync), 12'h1);
    chk({pfx, "_cl_rom"}, 12'(bus.cl_rom), 12'h1);
    chk({pfx, "_cm_rom"}, 12'(bus.cm_rom), 12'h0);
    chk({pfx, "_dbus_out"}, 12'(bus.dbus_out), 12'h0);
    chk({pfx, "_instr_vld"}, 12'(instr_vld), 12'h0);
    chk({pfx, "_rd_vld"}, 12'(rd_vld), 12'h0);
    chk({pfx, "_opr"}, 12'(opr), 12'h0);
    chk({pfx, "_opa"}, 12'(opa), 12'h0);
    chk({pfx, "_rd_data"}, 12'(rd_data), 12'h0);
    chk({pfx, "_bus_err"}, 12'(bus_err), 12'h0);
  endtask

  initial begin
    rst = 1'b1;
    pc_in = 12'h3A5;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // Plain fetch, SRC, WRR, RDR.
    run_cycle(12'h3A5, 8'hD7, 4'h0, 8'h00, 4'h0, 1'b0);
    run_cycle(12'h100, 8'h21, 4'h0, 8'hB4, 4'h0, 1'b0);
    run_cycle(12'h101, 8'hE2, 4'h9, 8'h00, 4'h0, 1'b0);
    run_cycle(12'h102, 8'hEA, 4'h0, 8'h00, 4'h6, 1'b0);

    // Abandon a cycle in M1; the next cycle must use the new pc_in.
    pc_in = 12'h2C0; rom = 8'hE0; rd_nib = '0; inj = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_phase", 12'(phase), 12'(M1));
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    @(posedge clk);
    #1;
    chk("mid_rst_hold_ivld", 12'(instr_vld), 12'h0);
    @(negedge clk);
    rst = 1'b0;
    first = 1'b1;
    exp_err = 1'b0;
    run_cycle(12'h456, 8'h3C, 4'h0, 8'h00, 4'h0, 1'b0);

    // Contention on A2, then a clean cycle: the flag must stay set.
    run_cycle(12'h3A5, 8'h00, 4'h0, 8'h00, 4'h0, 1'b1);
    run_cycle(12'h7F0, 8'h40, 4'h0, 8'h00, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
